// File: rtl/ball_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : ball_if
// Description : Frame-control inputs and position/status outputs of the
//               ball motion/collision engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface ball_if #(
    parameter int N_ENEMY = 4,
    parameter int W       = 10
);
    logic                 frame_tick;
    logic                 enable;
    logic [3:0]           keys;
    logic [W-1:0]         x_bola_aliada;
    logic [W-1:0]         y_bola_aliada;
    logic [N_ENEMY*W-1:0] x_bola_inimiga;
    logic [N_ENEMY*W-1:0] y_bola_inimiga;
    logic [W-1:0]         raio;
    logic                 perdeu;
    logic                 busy;
    logic                 update_done;

    modport master (
        output frame_tick, enable, keys,
        input  x_bola_aliada, y_bola_aliada, x_bola_inimiga, y_bola_inimiga,
               raio, perdeu, busy, update_done
    );

    modport slave (
        input  frame_tick, enable, keys,
        output x_bola_aliada, y_bola_aliada, x_bola_inimiga, y_bola_inimiga,
               raio, perdeu, busy, update_done
    );
endinterface
`default_nettype wire

// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
// Module      : ball_engine
// Description : Per-frame ally/enemy ball motion with edge bounce and sticky
//               box-collision detection; outputs change only on publish.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_engine #(
    parameter int N_ENEMY   = 4,
    parameter int W         = 10,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int RAIO      = 5,
    parameter int ALLY_STEP = 4,
    parameter int EN_SPEED  = 2,
    parameter int EN_X0     = 100,
    parameter int EN_DX0    = 60,
    parameter int EN_Y0     = 100
) (
    input wire   CLOCK_50,
    input wire   reset_n,
    ball_if.slave bus
);
    localparam int              c_IDX_W  = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(N_ENEMY - 1);
    localparam logic [W:0]      c_X_MAX  = (W+1)'(H_RES - 1 - RAIO);
    localparam logic [W:0]      c_Y_MAX  = (W+1)'(V_RES - 1 - RAIO);
    localparam logic [W:0]      c_RAIO   = (W+1)'(RAIO);
    localparam logic [W:0]      c_STEP   = (W+1)'(ALLY_STEP);
    localparam logic [W:0]      c_SPEED  = (W+1)'(EN_SPEED);
    localparam logic [W:0]      c_HIT    = (W+1)'(2 * RAIO);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ALLY    = 3'd1;
    localparam logic [2:0] c_ST_ENEMY   = 3'd2;
    localparam logic [2:0] c_ST_COLLIDE = 3'd3;
    localparam logic [2:0] c_ST_PUBLISH = 3'd4;

    logic [2:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [W-1:0]       r_ax, r_ay, r_out_ax, r_out_ay;
    logic [W-1:0]       r_ex [N_ENEMY];
    logic [W-1:0]       r_ey [N_ENEMY];
    logic [W-1:0]       r_out_ex [N_ENEMY];
    logic [W-1:0]       r_out_ey [N_ENEMY];
    logic [N_ENEMY-1:0] r_dx, r_dy;
    logic               r_hit, r_perdeu, r_busy, r_done;

    logic [W-1:0]       w_ax_nxt, w_ay_nxt;
    logic [W:0]         w_ex_mv, w_ey_mv;
    logic [W:0]         w_adx, w_ady;
    logic               w_hit;

    // Clamped ally move; W+1-bit arithmetic keeps the upper overshoot from wrapping.
    function automatic logic [W-1:0] f_ally_move(input logic [W:0] pos, input logic inc,
                                                 input logic dec, input logic [W:0] lim);
        logic [W:0] w_pos;
        w_pos = pos;
        if (inc && !dec)
            w_pos = (pos + c_STEP > lim) ? lim : pos + c_STEP;
        else if (dec && !inc)
            w_pos = (pos < c_RAIO + c_STEP) ? c_RAIO : pos - c_STEP;
        return W'(w_pos);
    endfunction

    // Returns {direction(1 = increasing), new position}.
    function automatic logic [W:0] f_enemy_move(input logic [W:0] pos, input logic dir_pos,
                                                input logic [W:0] lim);
        logic [W:0] w_pos;
        logic       w_dir;
        w_pos = pos;
        w_dir = dir_pos;
        if (dir_pos) begin
            if (pos + c_SPEED > lim) begin
                w_pos = lim;
                w_dir = 1'b0;
            end else begin
                w_pos = pos + c_SPEED;
            end
        end else begin
            if (pos < c_RAIO + c_SPEED) begin
                w_pos = c_RAIO;
                w_dir = 1'b1;
            end else begin
                w_pos = pos - c_SPEED;
            end
        end
        return {w_dir, W'(w_pos)};
    endfunction

    always_comb begin
        w_ax_nxt = f_ally_move({1'b0, r_ax}, bus.keys[0], bus.keys[1], c_X_MAX);
        w_ay_nxt = f_ally_move({1'b0, r_ay}, bus.keys[2], bus.keys[3], c_Y_MAX);
        w_ex_mv  = f_enemy_move({1'b0, r_ex[r_idx]}, r_dx[r_idx], c_X_MAX);
        w_ey_mv  = f_enemy_move({1'b0, r_ey[r_idx]}, r_dy[r_idx], c_Y_MAX);
        w_adx    = (r_ax >= r_ex[r_idx]) ? {1'b0, r_ax - r_ex[r_idx]} : {1'b0, r_ex[r_idx] - r_ax};
        w_ady    = (r_ay >= r_ey[r_idx]) ? {1'b0, r_ay - r_ey[r_idx]} : {1'b0, r_ey[r_idx] - r_ay};
        w_hit    = (w_adx <= c_HIT) && (w_ady <= c_HIT);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_ST_IDLE;
            r_idx    <= '0;
            r_ax     <= W'(300);
            r_ay     <= W'(300);
            r_out_ax <= W'(300);
            r_out_ay <= W'(300);
            for (int i = 0; i < N_ENEMY; i++) begin
                r_ex[i]     <= W'(EN_X0 + i * EN_DX0);
                r_ey[i]     <= W'(EN_Y0);
                r_out_ex[i] <= W'(EN_X0 + i * EN_DX0);
                r_out_ey[i] <= W'(EN_Y0);
                r_dx[i]     <= (i % 2 == 0);
                r_dy[i]     <= ((i / 2) % 2 == 0);
            end
            r_hit    <= 1'b0;
            r_perdeu <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.frame_tick && bus.enable && !r_perdeu) begin
                        r_state <= c_ST_ALLY;
                        r_busy  <= 1'b1;
                        r_hit   <= 1'b0;
                    end
                end
                c_ST_ALLY: begin
                    r_ax    <= w_ax_nxt;
                    r_ay    <= w_ay_nxt;
                    r_idx   <= '0;
                    r_state <= c_ST_ENEMY;
                end
                c_ST_ENEMY: begin
                    r_ex[r_idx] <= w_ex_mv[W-1:0];
                    r_dx[r_idx] <= w_ex_mv[W];
                    r_ey[r_idx] <= w_ey_mv[W-1:0];
                    r_dy[r_idx] <= w_ey_mv[W];
                    if (r_idx == c_LAST) begin
                        r_idx   <= '0;
                        r_state <= c_ST_COLLIDE;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                c_ST_COLLIDE: begin
                    if (w_hit)
                        r_hit <= 1'b1;
                    if (r_idx == c_LAST) begin
                        r_idx   <= '0;
                        r_state <= c_ST_PUBLISH;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                c_ST_PUBLISH: begin
                    r_out_ax <= r_ax;
                    r_out_ay <= r_ay;
                    for (int i = 0; i < N_ENEMY; i++) begin
                        r_out_ex[i] <= r_ex[i];
                        r_out_ey[i] <= r_ey[i];
                    end
                    r_perdeu <= r_perdeu | r_hit;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_ENEMY; i++) begin : g_pack
        assign bus.x_bola_inimiga[i*W +: W] = r_out_ex[i];
        assign bus.y_bola_inimiga[i*W +: W] = r_out_ey[i];
    end

    assign bus.x_bola_aliada = r_out_ax;
    assign bus.y_bola_aliada = r_out_ay;
    assign bus.raio          = W'(RAIO);
    assign bus.perdeu        = r_perdeu;
    assign bus.busy          = r_busy;
    assign bus.update_done   = r_done;
endmodule
`default_nettype wire

// File: tb/tb_ball_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_engine
// Description : Randomized frame stimulus for ball_engine against a
//               behavioural position/velocity model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_engine;
    localparam int N_ENEMY = 4, W = 10, H_RES = 640, V_RES = 480, RAIO = 5;
    localparam int ALLY_STEP = 4, EN_SPEED = 2, EN_X0 = 100, EN_DX0 = 60, EN_Y0 = 100;
    localparam int X_MAX = H_RES - 1 - RAIO;
    localparam int Y_MAX = V_RES - 1 - RAIO;
    localparam int LAT   = 2 * N_ENEMY + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ball_if #(.N_ENEMY(N_ENEMY), .W(W)) bus();

    ball_engine #(
        .N_ENEMY(N_ENEMY), .W(W), .H_RES(H_RES), .V_RES(V_RES), .RAIO(RAIO),
        .ALLY_STEP(ALLY_STEP), .EN_SPEED(EN_SPEED), .EN_X0(EN_X0), .EN_DX0(EN_DX0), .EN_Y0(EN_Y0)
    ) dut (
        .CLOCK_50(clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int m_ax, m_ay;
    int m_ex [N_ENEMY];
    int m_ey [N_ENEMY];
    int m_vx [N_ENEMY];
    int m_vy [N_ENEMY];
    bit m_perdeu;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_ax = 300;
        m_ay = 300;
        for (int i = 0; i < N_ENEMY; i++) begin
            m_ex[i] = EN_X0 + i * EN_DX0;
            m_ey[i] = EN_Y0;
            m_vx[i] = (i % 2 == 0) ? EN_SPEED : -EN_SPEED;
            m_vy[i] = ((i / 2) % 2 == 0) ? EN_SPEED : -EN_SPEED;
        end
        m_perdeu = 1'b0;
    endtask

    // Signed velocities; a move that would leave the playfield pins to the edge and reverses.
    task automatic model_frame(input logic [3:0] k);
        int nx, ny;
        m_ax = clamp(m_ax + (int'(k[0]) - int'(k[1])) * ALLY_STEP, RAIO, X_MAX);
        m_ay = clamp(m_ay + (int'(k[2]) - int'(k[3])) * ALLY_STEP, RAIO, Y_MAX);
        for (int i = 0; i < N_ENEMY; i++) begin
            nx = m_ex[i] + m_vx[i];
            ny = m_ey[i] + m_vy[i];
            if (nx > X_MAX || nx < RAIO) begin m_ex[i] = clamp(nx, RAIO, X_MAX); m_vx[i] = -m_vx[i]; end
            else m_ex[i] = nx;
            if (ny > Y_MAX || ny < RAIO) begin m_ey[i] = clamp(ny, RAIO, Y_MAX); m_vy[i] = -m_vy[i]; end
            else m_ey[i] = ny;
        end
        for (int i = 0; i < N_ENEMY; i++)
            if (iabs(m_ax - m_ex[i]) <= 2 * RAIO && iabs(m_ay - m_ey[i]) <= 2 * RAIO)
                m_perdeu = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_ally_x"}, bus.x_bola_aliada, m_ax);
        chk({tag, "_ally_y"}, bus.y_bola_aliada, m_ay);
        for (int i = 0; i < N_ENEMY; i++) begin
            chk($sformatf("%s_enemy_x%0d", tag, i), bus.x_bola_inimiga[i*W +: W], m_ex[i]);
            chk($sformatf("%s_enemy_y%0d", tag, i), bus.y_bola_inimiga[i*W +: W], m_ey[i]);
        end
        chk({tag, "_perdeu"}, bus.perdeu, m_perdeu);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_outputs("reset");
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.update_done, 0);
    endtask

    task automatic tick_frame(input logic [3:0] k, input bit en, input bit inject, input bit abort);
        bit acc;
        int lat, extra;
        @(posedge clk); #1;
        bus.keys       = k;
        bus.enable     = en;
        bus.frame_tick = 1'b1;
        acc = en && !m_perdeu;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        chk("busy_after_tick", bus.busy, acc);
        if (abort && acc) begin
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            model_reset();
            check_outputs("abort");
            chk("abort_busy", bus.busy, 0);
            chk("abort_done", bus.update_done, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
        end
        lat = 0;
        for (int c = 1; c <= LAT + 6 && lat == 0; c++) begin
            if (inject && c == 2) bus.enable = 1'b0;
            bus.frame_tick = inject && (c == 3);
            @(posedge clk); #1;
            if (bus.update_done) lat = c;
            else if (acc && c == LAT - 1) begin
                chk("hold_ally_x", bus.x_bola_aliada, m_ax);
                chk("hold_enemy_x0", bus.x_bola_inimiga[W-1:0], m_ex[0]);
            end
        end
        bus.frame_tick = 1'b0;
        if (acc) begin
            chk("latency", lat, LAT);
            model_frame(k);
            check_outputs("frame");
            chk("busy_at_done", bus.busy, 0);
            @(posedge clk); #1;
            chk("done_pulse_width", bus.update_done, 0);
            if (inject) begin
                extra = 0;
                repeat (LAT + 4) begin
                    @(posedge clk); #1;
                    if (bus.update_done || bus.busy) extra++;
                end
                chk("dropped_tick", extra, 0);
            end
        end else begin
            chk("no_update", lat, 0);
            check_outputs("ignored");
        end
    endtask

    initial begin
        logic [3:0] k, hold_k;
        int mode, tgt, frozen;
        bit en, inject, abort;
        bus.frame_tick = 1'b0;
        bus.enable     = 1'b0;
        bus.keys       = 4'b0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("por");
        chk("por_busy", bus.busy, 0);
        chk("por_done", bus.update_done, 0);
        chk("raio", bus.raio, RAIO);
        rst_n = 1'b1;

        tick_frame(4'b0001, 1'b1, 1'b0, 1'b0);
        chk("step_right_x", bus.x_bola_aliada, 304);
        tick_frame(4'b0011, 1'b1, 1'b0, 1'b0);
        chk("both_keys_x", bus.x_bola_aliada, 304);

        mode = 0; hold_k = 4'b0; tgt = 0; frozen = 0;
        for (int f = 0; f < 1500; f++) begin
            if (f % 50 == 0) begin
                mode   = $urandom_range(0, 2);
                hold_k = 4'($urandom);
                tgt    = $urandom_range(0, N_ENEMY - 1);
            end
            if (m_perdeu) frozen++;
            if (frozen > 2) begin
                do_reset();
                frozen = 0;
            end
            case (mode)
                0: k = 4'($urandom);
                1: k = hold_k;
                default: begin
                    k = {m_ey[tgt] < m_ay, m_ey[tgt] > m_ay, m_ex[tgt] < m_ax, m_ex[tgt] > m_ax};
                    if ($urandom_range(0, 3) == 0) k = 4'($urandom);
                end
            endcase
            en     = ($urandom_range(0, 15) != 0);
            inject = ($urandom_range(0, 9) == 0);
            abort  = ($urandom_range(0, 60) == 0);
            tick_frame(k, en, inject, abort);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
